vga_text_vram_sequencer: RTL and testbench

- Hardware fill/scroll engine for the VGA text VRAM: 1200 words, 2 chars/word, 40 words/row × 30 rows.
- Shares VRAM port A with the Avalon-MM slave path. Avalon always has priority; the engine uses only the cycles Avalon leaves free.
- Sits between the Avalon slave signals and the dual-port RAM's port A, inside the VGA text interface. Port B (VGA scan-out) and the palette registers are untouched.

---
 rtl/vga_text_pkg.sv | 28 ++
 rtl/vga_text_vram_sequencer.sv | 150 +++++++++++++++
 tb/tb_vga_text_vram_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// ============================================================================
// Module : vga_text_pkg
// Brief  : Shared constants and state type for the VGA text VRAM sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_text_pkg;

  localparam logic [1:0] OP_FILL   = 2'd0;
  localparam logic [1:0] OP_SCROLL = 2'd1;

  localparam int ROW_WORDS  = 40;
  localparam int ROWS       = 30;
  localparam int VRAM_WORDS = ROW_WORDS * ROWS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_SC_RD  = 3'd2,
    ST_SC_CAP = 3'd3,
    ST_SC_WR  = 3'd4,
    ST_FIN    = 3'd5
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_text_vram_sequencer.sv
// ============================================================================
// Module : vga_text_vram_sequencer
// Brief  : Fill/scroll engine sharing VRAM port A; Avalon always wins the port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_text_vram_sequencer #(
  parameter int ROW_WORDS = 40,
  parameter int ROWS      = 30,
  parameter int ADDR_W    = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [11:0]       AVL_ADDR,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [31:0]       AVL_WRITEDATA,
  input  logic              CMD_START,
  input  logic [1:0]        CMD_OP,
  input  logic [31:0]       CMD_FILL_WORD,
  input  logic [31:0]       RAM_Q,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [3:0]        RAM_BYTE_EN,
  output logic [31:0]       RAM_WDATA,
  output logic              RAM_RDEN,
  output logic              RAM_WREN,
  output logic              BUSY,
  output logic              DONE
);

  import vga_text_pkg::*;

  localparam logic [ADDR_W-1:0] c_ROW_OFS     = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] c_LAST_FILL   = ADDR_W'(ROW_WORDS * ROWS - 1);
  localparam logic [ADDR_W-1:0] c_LAST_SCROLL = ADDR_W'(ROW_WORDS * (ROWS - 1) - 1);
  localparam logic [ADDR_W-1:0] c_ONE         = ADDR_W'(1);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [31:0]       r_fill;
  logic [31:0]       r_cap;

  logic              w_avl_vram;
  logic              w_port_free;
  logic              w_start_ok;
  logic              w_eng_rd;
  logic              w_eng_wr;
  logic [ADDR_W-1:0] w_eng_addr;
  logic [31:0]       w_eng_data;

  assign w_avl_vram  = AVL_CS & (AVL_READ | AVL_WRITE) & ~AVL_ADDR[11];
  assign w_port_free = ~w_avl_vram;
  assign w_start_ok  = CMD_START & ((CMD_OP == OP_FILL) | (CMD_OP == OP_SCROLL));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_fill  <= '0;
      r_cap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == ST_IDLE && w_start_ok) begin
        r_fill <= CMD_FILL_WORD;
      end
      if (r_state == ST_SC_CAP) begin
        r_cap <= RAM_Q;
      end
    end
  end

  // Scroll falls through into FILL so the last row reuses the fill loop.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_eng_rd    = 1'b0;
    w_eng_wr    = 1'b0;
    w_eng_addr  = r_idx;
    w_eng_data  = r_fill;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_idx_nxt   = '0;
          w_state_nxt = (CMD_OP == OP_FILL) ? ST_FILL : ST_SC_RD;
        end
      end
      ST_FILL: begin
        if (w_port_free) begin
          w_eng_wr  = 1'b1;
          w_idx_nxt = r_idx + c_ONE;
          if (r_idx == c_LAST_FILL) begin
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_SC_RD: begin
        w_eng_addr = r_idx + c_ROW_OFS;
        if (w_port_free) begin
          w_eng_rd    = 1'b1;
          w_state_nxt = ST_SC_CAP;
        end
      end
      ST_SC_CAP: begin
        w_state_nxt = ST_SC_WR;
      end
      ST_SC_WR: begin
        w_eng_data = r_cap;
        if (w_port_free) begin
          w_eng_wr    = 1'b1;
          w_idx_nxt   = r_idx + c_ONE;
          w_state_nxt = (r_idx == c_LAST_SCROLL) ? ST_FILL : ST_SC_RD;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Engine strobes are masked during reset so an aborted command stops at once.
  always_comb begin
    RAM_ADDR    = w_eng_addr;
    RAM_BYTE_EN = 4'hF;
    RAM_WDATA   = w_eng_data;
    RAM_RDEN    = w_eng_rd & ~RESET;
    RAM_WREN    = w_eng_wr & ~RESET;
    if (w_avl_vram) begin
      RAM_ADDR    = AVL_ADDR[ADDR_W-1:0];
      RAM_BYTE_EN = AVL_BYTE_EN;
      RAM_WDATA   = AVL_WRITEDATA;
      RAM_RDEN    = AVL_READ;
      RAM_WREN    = AVL_WRITE;
    end
  end

  assign DONE = (r_state == ST_FIN);
  assign BUSY = (r_state != ST_IDLE) && (r_state != ST_FIN);

endmodule

`default_nettype wire

// File: tb/tb_vga_text_vram_sequencer.sv
// ============================================================================
// Module : tb_vga_text_vram_sequencer
// Brief  : Directed bench for the VRAM fill/scroll sequencer with a port-A RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_text_vram_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        AVL_CS, AVL_READ, AVL_WRITE;
  logic [11:0] AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_WRITEDATA;
  logic        CMD_START;
  logic [1:0]  CMD_OP;
  logic [31:0] CMD_FILL_WORD;
  logic [31:0] RAM_Q;
  logic [10:0] RAM_ADDR;
  logic [3:0]  RAM_BYTE_EN;
  logic [31:0] RAM_WDATA;
  logic        RAM_RDEN, RAM_WREN, BUSY, DONE;

  logic [31:0] mem [0:2047];
  logic [31:0] r_q = '0;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  vga_text_vram_sequencer #(.ROW_WORDS(40), .ROWS(30), .ADDR_W(11)) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
    .CMD_START(CMD_START), .CMD_OP(CMD_OP), .CMD_FILL_WORD(CMD_FILL_WORD),
    .RAM_Q(RAM_Q), .RAM_ADDR(RAM_ADDR), .RAM_BYTE_EN(RAM_BYTE_EN),
    .RAM_WDATA(RAM_WDATA), .RAM_RDEN(RAM_RDEN), .RAM_WREN(RAM_WREN),
    .BUSY(BUSY), .DONE(DONE)
  );

  // Port-A RAM: byte-enabled writes, one-cycle registered read.
  assign RAM_Q = r_q;
  always @(posedge CLK) begin
    if (RAM_WREN) begin
      for (int b = 0; b < 4; b++) begin
        if (RAM_BYTE_EN[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
      end
    end
    if (RAM_RDEN) r_q <= mem[RAM_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_avl(input logic cs, input logic rd, input logic wr,
                         input logic [11:0] addr, input logic [31:0] data);
    AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr;
    AVL_ADDR = addr; AVL_WRITEDATA = data; AVL_BYTE_EN = 4'hF;
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [31:0] word);
    CMD_OP = op; CMD_FILL_WORD = word; CMD_START = 1'b1;
    tick();
    CMD_START = 1'b0;
  endtask

  task automatic wait_done(input int bound, inout int n);
    while (DONE !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic preload(input logic [31:0] base);
    for (int i = 0; i < 1200; i++) begin
      set_avl(1'b1, 1'b0, 1'b1, 12'(i), base + 32'(i));
      tick();
    end
    set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  initial begin
    int n, k, e, bad;
    RESET = 1'b1; CMD_START = 1'b0; CMD_OP = 2'd0; CMD_FILL_WORD = '0;
    set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    chk("reset_ctl", {28'h0, BUSY, DONE, RAM_WREN, RAM_RDEN}, 32'h0);
    chk("reset_be", {28'h0, RAM_BYTE_EN}, 32'hF);

    // Plain FILL: 1200 back-to-back writes, DONE at start+1201.
    start_cmd(2'd0, 32'h0F200F20);
    for (int c = 1; c <= 1200; c++) begin
      chk("fill_addr", {21'h0, RAM_ADDR}, 32'(c - 1));
      chk("fill_ctl", {24'h0, RAM_WREN, RAM_RDEN, BUSY, DONE, RAM_BYTE_EN}, 32'hAF);
      chk("fill_data", RAM_WDATA, 32'h0F200F20);
      tick();
    end
    chk("fill_done", {30'h0, DONE, BUSY}, 32'h2);
    tick();
    chk("fill_done_pulse", {31'h0, DONE}, 32'h0);
    bad = 0;
    for (int i = 0; i < 1200; i++) if (mem[i] !== 32'h0F200F20) bad++;
    chk("fill_mem", 32'(bad), 32'h0);

    // Idle Avalon read through the mux.
    preload(32'h0);
    set_avl(1'b1, 1'b1, 1'b0, 12'd7, 32'h0);
    #1;
    chk("avl_rd_strobe", {30'h0, RAM_RDEN, RAM_WREN}, 32'h2);
    tick();
    set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("avl_rd_q", RAM_Q, 32'd7);

    // SCROLL_UP with fill 0.
    start_cmd(2'd1, 32'h0);
    n = 1;
    wait_done(4000, n);
    chk("scroll_done_cycle", 32'(n), 32'd3521);
    chk("scroll_busy_in_done", {31'h0, BUSY}, 32'h0);
    bad = 0;
    for (int i = 0; i < 1200; i++)
      if (mem[i] !== ((i < 1160) ? 32'(i + 40) : 32'h0)) bad++;
    chk("scroll_mem", 32'(bad), 32'h0);
    tick();

    // FILL with an Avalon VRAM write to word 5 every 4th cycle.
    start_cmd(2'd0, 32'h12345678);
    n = 1; k = 0; e = 0;
    while (DONE !== 1'b1 && n < 3000) begin
      if (n % 4 == 0 && n <= 1200) begin
        set_avl(1'b1, 1'b0, 1'b1, 12'd5, 32'hAAAA5555);
        k++;
        #1;
        chk("stall_ctl", {26'h0, RAM_WREN, RAM_RDEN, RAM_BYTE_EN}, 32'h2F);
        chk("stall_addr", {21'h0, RAM_ADDR}, 32'd5);
        chk("stall_data", RAM_WDATA, 32'hAAAA5555);
      end else begin
        set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        #1;
        chk("stall_eng_addr", {21'h0, RAM_ADDR}, 32'(e));
        e++;
      end
      tick();
      n++;
    end
    set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    chk("stall_done_cycle", 32'(n), 32'(1201 + k));
    tick();
    chk("stall_word5", mem[5], 32'hAAAA5555);
    chk("stall_word6", mem[6], 32'h12345678);
    chk("stall_word1199", mem[1199], 32'h12345678);

    // SCROLL_UP with Avalon reads of word 0 in SC_RD and SC_WR.
    preload(32'h100);
    start_cmd(2'd1, 32'h0000DEAD);
    set_avl(1'b1, 1'b1, 1'b0, 12'd0, 32'h0);
    #1;
    chk("scr_avl_rd1", {19'h0, RAM_RDEN, RAM_WREN, RAM_ADDR}, 32'h1000);
    tick();
    set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("scr_avl_q1", RAM_Q, 32'h100);
    chk("scr_eng_rd", {19'h0, RAM_RDEN, RAM_WREN, RAM_ADDR}, 32'h1028);
    tick();
    chk("scr_cap_idle", {30'h0, RAM_RDEN, RAM_WREN}, 32'h0);
    tick();
    set_avl(1'b1, 1'b1, 1'b0, 12'd0, 32'h0);
    #1;
    chk("scr_avl_rd2", {19'h0, RAM_RDEN, RAM_WREN, RAM_ADDR}, 32'h1000);
    tick();
    set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("scr_avl_q2", RAM_Q, 32'h100);
    chk("scr_eng_wr", {19'h0, RAM_RDEN, RAM_WREN, RAM_ADDR}, 32'h0800);
    chk("scr_eng_wdata", RAM_WDATA, 32'h128);
    n = 5;
    wait_done(5000, n);
    chk("scr_rd_done_cycle", 32'(n), 32'd3523);
    bad = 0;
    for (int i = 0; i < 1200; i++)
      if (mem[i] !== ((i < 1160) ? 32'(i + 40 + 32'h100) : 32'h0000DEAD)) bad++;
    chk("scr_rd_mem", 32'(bad), 32'h0);
    tick();

    // Palette writes during FILL neither stall nor reach the RAM.
    start_cmd(2'd0, 32'h0B0B0B0B);
    n = 1;
    while (DONE !== 1'b1 && n < 3000) begin
      if (n >= 10 && n <= 12) begin
        set_avl(1'b1, 1'b0, 1'b1, 12'h800, 32'hFFFFFFFF);
        #1;
        chk("pal_addr", {20'h0, RAM_WREN, RAM_ADDR}, 32'h800 | 32'(n - 1));
        chk("pal_data", RAM_WDATA, 32'h0B0B0B0B);
      end else begin
        set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
      end
      tick();
      n++;
    end
    set_avl(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    chk("pal_done_cycle", 32'(n), 32'd1201);
    tick();

    // Second start while BUSY is ignored.
    start_cmd(2'd0, 32'hA1A1A1A1);
    n = 1;
    repeat (4) begin tick(); n++; end
    CMD_OP = 2'd1; CMD_FILL_WORD = 32'hB2B2B2B2; CMD_START = 1'b1;
    tick(); n++;
    CMD_START = 1'b0;
    wait_done(3000, n);
    chk("busy_start_done", 32'(n), 32'd1201);
    bad = 0;
    for (int i = 0; i < 1200; i++) if (mem[i] !== 32'hA1A1A1A1) bad++;
    chk("busy_start_mem", 32'(bad), 32'h0);
    tick();

    // Reserved OP gives neither BUSY nor DONE.
    start_cmd(2'd2, 32'hCCCCCCCC);
    bad = 0;
    repeat (6) begin
      if (BUSY !== 1'b0 || DONE !== 1'b0 || RAM_WREN !== 1'b0) bad++;
      tick();
    end
    chk("op2_quiet", 32'(bad), 32'h0);

    // RESET at FILL idx 600 aborts without DONE.
    start_cmd(2'd0, 32'h77777777);
    repeat (600) tick();
    chk("rst_at_600", {21'h0, RAM_ADDR}, 32'd600);
    RESET = 1'b1;
    #1;
    chk("rst_no_wr", {31'h0, RAM_WREN}, 32'h0);
    tick();
    RESET = 1'b0;
    chk("rst_idle", {30'h0, BUSY, DONE}, 32'h0);
    bad = 0;
    repeat (700) begin
      if (DONE !== 1'b0 || BUSY !== 1'b0) bad++;
      tick();
    end
    chk("rst_no_done", 32'(bad), 32'h0);
    bad = 0;
    for (int i = 0; i < 1200; i++)
      if (mem[i] !== ((i < 600) ? 32'h77777777 : 32'hA1A1A1A1)) bad++;
    chk("rst_mem", 32'(bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
